vote_frame_loader: RTL
======================

VOTE_FRAME_LOADER -- requirements
Module: vote_frame_loader

Interface
REQ-001 The block SHALL expose exactly two ports: io_in [7:0] input and io_out [7:0] output.
REQ-002 Bit map of io_in: io_in[0]  in  1  clk, the single clock, rising-edge.
REQ-003 io_in[1]  in  1  rst_n, asynchronous, active-low reset.
REQ-004 io_in[2]  in  1  sdata, the serial frame data, MSB first.
REQ-005 io_in[3]  in  1  sframe, high for every bit-cycle of a frame.
REQ-006 io_in[4]  in  1  ack, downstream has captured the presented bank.
REQ-007 io_in[7:5]  in  3  unused; ignored.
REQ-008 Bit map of io_out: io_out[4:0]  out  5  bank_data, the presented 5-bit bank.
REQ-009 io_out[5]  out  1  bank_sel: 0 = bank A, 1 = bank B.
REQ-010 io_out[6]  out  1  valid, bank_data/bank_sel stable and presented.
REQ-011 io_out[7]  out  1  err, last frame aborted or failed parity.

Function
REQ-012 The frame SHALL be 11 bits, sampled one per rising clk edge while sframe=1: A[4:0], B[4:0], then P; MSB first.
REQ-013 P SHALL be even parity over all 10 data bits; a frame passes when the XOR of all 11 bits is 0.
REQ-014 The FSM SHALL have states IDLE, RECV, CHECK, PRES_A, PRES_B, ERR.
REQ-015 IDLE->RECV: edge with sframe=1; that edge captures bit 0 (A[4]).
REQ-016 RECV: shift sdata on each edge with sframe=1; a 4-bit counter reaches 10 -> CHECK on the edge capturing P.
REQ-017 RECV with sframe=0 before 11 bits -> ERR, err=1, no bank presented.
REQ-018 CHECK lasts one cycle: parity pass -> PRES_A, err cleared; fail -> ERR, err=1.
REQ-019 PRES_A: valid=1, bank_sel=0, bank_data=A; an edge with ack=1 -> PRES_B.
REQ-020 PRES_B: valid=1, bank_sel=1, bank_data=B; an edge with ack=1 -> IDLE, valid=0.
REQ-021 Outputs SHALL be registered; valid rises the cycle after CHECK (2 cycles after the P edge).
REQ-022 ack while valid=0 SHALL be ignored; held ack advances at most one bank per edge.
REQ-023 sframe=1 in PRES_A/PRES_B SHALL be ignored; the frame is lost and bits are not buffered.
REQ-024 ERR: valid=0, err=1; sframe=1 -> RECV (same as IDLE), err held until next CHECK pass.
REQ-025 bank_data SHALL hold its last value when valid=0.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, counter=0, shift reg=0, io_out=8'h00.
REQ-027 Reset mid-RECV or mid-PRES SHALL discard the frame with no valid pulse after release.
REQ-028 The first edge after rst_n rises SHALL be treated as IDLE.

Structure
REQ-029 Package vote_frame_pkg SHALL hold the state enum, FRAME_BITS=11, BANK_W=5 and CNT_W=4.
REQ-030 One sub-module, frame_shift_rx, SHALL contain the 11-bit shift register, bit counter and running parity.
REQ-031 The FSM and output registers SHALL be in vote_frame_loader.

Verification
REQ-032 Frame A=10110, B=01001, P=1 (bits 1,0,1,1,0,0,1,0,0,1,1), ack after 2 cycles per bank -> io_out=8'h56, then 8'h69, then valid=0, err=0.
REQ-033 Same frame with P=0 -> ERR, io_out[7]=1, valid never rises; a following good frame clears err.
REQ-034 sframe drops after 6 bits -> err=1, no valid; the next full frame is accepted.
REQ-035 ack held high continuously -> PRES_A and PRES_B last exactly one cycle each, then IDLE.
REQ-036 rst_n pulsed low during PRES_A -> io_out=8'h00 asynchronously, no further valid until a new frame.
REQ-037 New frame asserted during PRES_B -> ignored; B is presented until ack, then IDLE.

Source files
------------

// File: rtl/vote_frame_pkg.sv
// ----------------------------------------------------------------------------
// vote_frame_pkg
// Shared constants and types for the vote frame loader.
//   FRAME_BITS : bits per serial frame (A[4:0], B[4:0], P)
//   BANK_W     : width of one presented bank
//   CNT_W      : width of the received-bit counter
//   state_e    : loader FSM states (fixed encoding)
// No ports.
// ----------------------------------------------------------------------------
package vote_frame_pkg;

   localparam int FRAME_BITS = 11;
   localparam int BANK_W     = 5;
   localparam int CNT_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RECV   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_PRES_A = 3'd3,
      ST_PRES_B = 3'd4,
      ST_ERR    = 3'd5
   } state_e;

   // Bank A occupies the first BANK_W bits received, which end up at the top
   // of the shift register once the whole frame has been shifted in.
   function automatic logic [BANK_W-1:0] bank_a_of(input logic [FRAME_BITS-1:0] f);
      return f[FRAME_BITS-1 -: BANK_W];
   endfunction

   function automatic logic [BANK_W-1:0] bank_b_of(input logic [FRAME_BITS-1:0] f);
      return f[FRAME_BITS-1-BANK_W -: BANK_W];
   endfunction

endpackage

// File: rtl/vote_frame_loader_if.sv
// ----------------------------------------------------------------------------
// vote_frame_loader_if
// Link between the loader FSM (master) and the frame receiver (slave).
//   sdata     : serial data bit for the current edge          (master -> slave)
//   start     : capture sdata as bit 0 of a new frame         (master -> slave)
//   shift     : capture sdata as the next bit of the frame    (master -> slave)
//   last_bit  : the next captured bit is the parity bit P     (slave -> master)
//   parity_ok : XOR of all captured bits is zero              (slave -> master)
//   bank_a    : received bank A                               (slave -> master)
//   bank_b    : received bank B                               (slave -> master)
// ----------------------------------------------------------------------------
interface vote_frame_loader_if;
   import vote_frame_pkg::*;

   logic              sdata;
   logic              start;
   logic              shift;
   logic              last_bit;
   logic              parity_ok;
   logic [BANK_W-1:0] bank_a;
   logic [BANK_W-1:0] bank_b;

   modport master (
      output sdata, start, shift,
      input  last_bit, parity_ok, bank_a, bank_b
   );

   modport slave (
      input  sdata, start, shift,
      output last_bit, parity_ok, bank_a, bank_b
   );

endinterface

// File: rtl/frame_shift_rx.sv
// ----------------------------------------------------------------------------
// frame_shift_rx
// Serial frame receiver: 11-bit MSB-first shift register, received-bit
// counter and running parity. Captures only when told to by the FSM.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   link  : slave side of vote_frame_loader_if
// ----------------------------------------------------------------------------
module frame_shift_rx
   import vote_frame_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   vote_frame_loader_if.slave link
);

   logic [FRAME_BITS-1:0] shreg;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  parity;
   logic                  unused_pbit;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         parity  <= 1'b0;
      end else if (link.start) begin
         // A new frame restarts from a clean register, so stale bits of an
         // aborted frame never leak into the banks.
         shreg   <= {{(FRAME_BITS-1){1'b0}}, link.sdata};
         bit_cnt <= CNT_W'(1);
         parity  <= link.sdata;
      end else if (link.shift) begin
         shreg   <= {shreg[FRAME_BITS-2:0], link.sdata};
         bit_cnt <= bit_cnt + CNT_W'(1);
         parity  <= parity ^ link.sdata;
      end
   end

   // bit_cnt counts captured bits, so the bit about to be captured is P when
   // FRAME_BITS-1 bits are already in.
   assign link.last_bit  = (bit_cnt == CNT_W'(FRAME_BITS - 1));
   assign link.parity_ok = ~parity;
   assign link.bank_a    = bank_a_of(shreg);
   assign link.bank_b    = bank_b_of(shreg);

   // The parity bit itself is only needed through the running parity.
   assign unused_pbit = shreg[0];

endmodule

// File: rtl/vote_frame_loader.sv
// ----------------------------------------------------------------------------
// vote_frame_loader
// Receives an 11-bit serial frame (A[4:0], B[4:0], even parity P), checks
// parity and presents bank A then bank B, each until acknowledged.
//   io_in[0]   clk     rising-edge clock
//   io_in[1]   rst_n   asynchronous active-low reset
//   io_in[2]   sdata   serial frame data, MSB first
//   io_in[3]   sframe  high for every bit-cycle of a frame
//   io_in[4]   ack     downstream captured the presented bank
//   io_in[7:5] unused
//   io_out[4:0] bank_data  presented bank (holds when not valid)
//   io_out[5]   bank_sel   0 = bank A, 1 = bank B
//   io_out[6]   valid      bank_data/bank_sel presented
//   io_out[7]   err        last frame aborted or failed parity
// ----------------------------------------------------------------------------
module vote_frame_loader
   import vote_frame_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic clk;
   logic rst_n;
   logic sdata;
   logic sframe;
   logic ack;
   logic unused_io;

   assign clk       = io_in[0];
   assign rst_n     = io_in[1];
   assign sdata     = io_in[2];
   assign sframe    = io_in[3];
   assign ack       = io_in[4];
   assign unused_io = ^io_in[7:5];

   vote_frame_loader_if link ();

   frame_shift_rx u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .link  (link)
   );

   state_e            state;
   logic              err_q;
   logic              valid_q;
   logic              sel_q;
   logic [BANK_W-1:0] data_q;

   assign link.sdata = sdata;

   // IDLE and ERR both open a frame on sframe; only RECV keeps shifting.
   // sframe in CHECK/PRES_* is deliberately not forwarded: those bits are lost.
   always_comb begin
      // NOTE: give every always_comb output a default first so no branch
      // leaves it unassigned and infers a latch.
      link.start = 1'b0;
      link.shift = 1'b0;
      case (state)
         ST_IDLE, ST_ERR: link.start = sframe;
         ST_RECV:         link.shift = sframe;
         default:         ;
      endcase
   end

   // FSM and output registers share one block so outputs change on the same
   // edge as the state that defines them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         sel_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_ERR: begin
               // err is left alone: it only clears on a passing CHECK.
               if (sframe) state <= ST_RECV;
            end

            ST_RECV: begin
               if (!sframe) begin
                  state <= ST_ERR;
                  err_q <= 1'b1;
               end else if (link.last_bit) begin
                  state <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (link.parity_ok) begin
                  state   <= ST_PRES_A;
                  err_q   <= 1'b0;
                  valid_q <= 1'b1;
                  sel_q   <= 1'b0;
                  data_q  <= link.bank_a;
               end else begin
                  state <= ST_ERR;
                  err_q <= 1'b1;
               end
            end

            ST_PRES_A: begin
               if (ack) begin
                  state  <= ST_PRES_B;
                  sel_q  <= 1'b1;
                  data_q <= link.bank_b;
               end
            end

            ST_PRES_B: begin
               // bank_data/bank_sel keep their last value once valid drops.
               if (ack) begin
                  state   <= ST_IDLE;
                  valid_q <= 1'b0;
               end
            end

            default: begin
               state   <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign io_out = {err_q, valid_q, sel_q, data_q};

endmodule
